// File: rtl/pcie_app_endpoint.sv
// Application-side endpoint of the virtualized PCIe packet channel: delivers
// per-app packets as command messages and tags responses with their slot.
module pcie_app_endpoint #(
  parameter int DATA_WIDTH      = 128,
  parameter int SLOT_WIDTH      = 16,
  parameter int PAD_WIDTH       = 4,
  parameter int RX_LOG_DEPTH    = 4,
  parameter int TX_LOG_DEPTH    = 4,
  parameter int SLOTQ_LOG_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pkt_in_valid,
  input  logic [DATA_WIDTH-1:0] pkt_in_data,
  input  logic [SLOT_WIDTH-1:0] pkt_in_slot,
  input  logic [PAD_WIDTH-1:0]  pkt_in_pad,
  input  logic                  pkt_in_last,
  output logic                  pkt_full_out,
  output logic                  pkt_out_valid,
  output logic [DATA_WIDTH-1:0] pkt_out_data,
  output logic [SLOT_WIDTH-1:0] pkt_out_slot,
  output logic [PAD_WIDTH-1:0]  pkt_out_pad,
  output logic                  pkt_out_last,
  input  logic                  pkt_grant_in,
  output logic                  cmd_valid,
  output logic [DATA_WIDTH-1:0] cmd_data,
  output logic [SLOT_WIDTH-1:0] cmd_slot,
  output logic                  cmd_last,
  input  logic                  cmd_ready,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  input  logic [PAD_WIDTH-1:0]  rsp_pad,
  input  logic                  rsp_last,
  output logic                  rsp_ready,
  output logic                  err_slot_mismatch,
  output logic [15:0]           rx_msg_count,
  output logic [15:0]           tx_msg_count
);

  localparam int RX_DEPTH = 1 << RX_LOG_DEPTH;
  localparam int TX_DEPTH = 1 << TX_LOG_DEPTH;
  localparam int SQ_DEPTH = 1 << SLOTQ_LOG_DEPTH;

  typedef struct packed {
    logic                  first;
    logic                  last;
    logic [SLOT_WIDTH-1:0] slot;
    logic [DATA_WIDTH-1:0] data;
  } rx_beat_t;

  typedef struct packed {
    logic                  last;
    logic [PAD_WIDTH-1:0]  pad;
    logic [SLOT_WIDTH-1:0] slot;
    logic [DATA_WIDTH-1:0] data;
  } tx_beat_t;

  typedef enum logic {RX_IDLE, RX_INMSG} rx_state_t;

  rx_beat_t                    rx_mem [RX_DEPTH];
  logic [RX_LOG_DEPTH-1:0]     rx_wr_ptr, rx_rd_ptr;
  logic [RX_LOG_DEPTH:0]       rx_count;
  rx_beat_t                    rx_head, rx_wbeat;
  rx_state_t                   rx_state;
  logic [SLOT_WIDTH-1:0]       msg_slot;
  logic                        rx_accept, rx_drop, rx_push, rx_pop;

  logic [SLOT_WIDTH-1:0]       sq_mem [SQ_DEPTH];
  logic [SLOTQ_LOG_DEPTH-1:0]  sq_wr_ptr, sq_rd_ptr;
  logic [SLOTQ_LOG_DEPTH:0]    sq_count;
  logic                        sq_full, sq_empty, sq_push, sq_pop;

  tx_beat_t                    tx_mem [TX_DEPTH];
  logic [TX_LOG_DEPTH-1:0]     tx_wr_ptr, tx_rd_ptr;
  logic [TX_LOG_DEPTH:0]       tx_count;
  tx_beat_t                    tx_head, tx_wbeat;
  logic                        tx_full, tx_push, tx_pop;

  // Commands carry no pad field; the incoming pad is intentionally dropped.
  logic unused_pad;
  assign unused_pad = ^pkt_in_pad;

  // Receive side: beats that break the current message's slot never enter the FIFO.
  assign pkt_full_out = (rx_count == (RX_LOG_DEPTH+1)'(RX_DEPTH));
  assign rx_accept    = pkt_in_valid && !pkt_full_out;
  assign rx_drop      = (rx_state == RX_INMSG) && (pkt_in_slot != msg_slot);
  assign rx_push      = rx_accept && !rx_drop;
  assign rx_wbeat     = '{first: (rx_state == RX_IDLE), last: pkt_in_last,
                          slot: pkt_in_slot, data: pkt_in_data};
  assign rx_head      = rx_mem[rx_rd_ptr];

  // A new message is only offered to the user once its slot can be tracked.
  assign sq_full   = (sq_count == (SLOTQ_LOG_DEPTH+1)'(SQ_DEPTH));
  assign sq_empty  = (sq_count == '0);
  assign cmd_valid = (rx_count != '0) && !(rx_head.first && sq_full);
  assign cmd_data  = rx_head.data;
  assign cmd_slot  = rx_head.slot;
  assign cmd_last  = rx_head.last;
  assign rx_pop    = cmd_valid && cmd_ready;
  assign sq_push   = rx_pop && rx_head.first;

  assign tx_full   = (tx_count == (TX_LOG_DEPTH+1)'(TX_DEPTH));
  assign rsp_ready = !sq_empty && !tx_full;
  assign tx_push   = rsp_valid && rsp_ready;
  assign sq_pop    = tx_push && rsp_last;
  assign tx_wbeat  = '{last: rsp_last, pad: rsp_pad, slot: sq_mem[sq_rd_ptr], data: rsp_data};

  assign tx_head       = tx_mem[tx_rd_ptr];
  assign pkt_out_valid = (tx_count != '0);
  assign pkt_out_data  = tx_head.data;
  assign pkt_out_slot  = tx_head.slot;
  assign pkt_out_pad   = tx_head.pad;
  assign pkt_out_last  = tx_head.last;
  assign tx_pop        = pkt_out_valid && pkt_grant_in;

  // NOTE: storage arrays have no reset; the reset counts alone mark them empty.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_wbeat;
    if (sq_push) sq_mem[sq_wr_ptr] <= rx_head.slot;
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_wbeat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      sq_wr_ptr <= '0;
      sq_rd_ptr <= '0;
      sq_count  <= '0;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_LOG_DEPTH'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_LOG_DEPTH'(1);
      rx_count <= rx_count + (RX_LOG_DEPTH+1)'(rx_push) - (RX_LOG_DEPTH+1)'(rx_pop);
      if (sq_push) sq_wr_ptr <= sq_wr_ptr + SLOTQ_LOG_DEPTH'(1);
      if (sq_pop)  sq_rd_ptr <= sq_rd_ptr + SLOTQ_LOG_DEPTH'(1);
      sq_count <= sq_count + (SLOTQ_LOG_DEPTH+1)'(sq_push) - (SLOTQ_LOG_DEPTH+1)'(sq_pop);
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_LOG_DEPTH'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_LOG_DEPTH'(1);
      tx_count <= tx_count + (TX_LOG_DEPTH+1)'(tx_push) - (TX_LOG_DEPTH+1)'(tx_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state          <= RX_IDLE;
      msg_slot          <= '0;
      err_slot_mismatch <= 1'b0;
      rx_msg_count      <= '0;
    end else if (rx_accept) begin
      case (rx_state)
        RX_IDLE: begin
          if (pkt_in_last) begin
            rx_msg_count <= rx_msg_count + 16'd1;
          end else begin
            rx_state <= RX_INMSG;
            msg_slot <= pkt_in_slot;
          end
        end
        RX_INMSG: begin
          if (rx_drop) begin
            err_slot_mismatch <= 1'b1;
          end else if (pkt_in_last) begin
            rx_state     <= RX_IDLE;
            rx_msg_count <= rx_msg_count + 16'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_msg_count <= '0;
    else if (sq_pop) tx_msg_count <= tx_msg_count + 16'd1;
  end

endmodule

// File: tb/tb_pcie_app_endpoint.sv
// Scoreboard bench for pcie_app_endpoint: drivers queue expected command and
// outgoing packet beats, monitors compare them whenever a handshake fires.
module tb_pcie_app_endpoint;
  localparam int DW = 128;
  localparam int SW = 16;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pkt_in_valid = 1'b0;
  logic [DW-1:0] pkt_in_data = '0;
  logic [SW-1:0] pkt_in_slot = '0;
  logic [PW-1:0] pkt_in_pad = '0;
  logic          pkt_in_last = 1'b0;
  logic          pkt_full_out;
  logic          pkt_out_valid;
  logic [DW-1:0] pkt_out_data;
  logic [SW-1:0] pkt_out_slot;
  logic [PW-1:0] pkt_out_pad;
  logic          pkt_out_last;
  logic          pkt_grant_in = 1'b0;
  logic          cmd_valid;
  logic [DW-1:0] cmd_data;
  logic [SW-1:0] cmd_slot;
  logic          cmd_last;
  logic          cmd_ready = 1'b0;
  logic          rsp_valid = 1'b0;
  logic [DW-1:0] rsp_data = '0;
  logic [PW-1:0] rsp_pad = '0;
  logic          rsp_last = 1'b0;
  logic          rsp_ready;
  logic          err_slot_mismatch;
  logic [15:0]   rx_msg_count;
  logic [15:0]   tx_msg_count;

  pcie_app_endpoint dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_in_valid(pkt_in_valid), .pkt_in_data(pkt_in_data), .pkt_in_slot(pkt_in_slot),
    .pkt_in_pad(pkt_in_pad), .pkt_in_last(pkt_in_last), .pkt_full_out(pkt_full_out),
    .pkt_out_valid(pkt_out_valid), .pkt_out_data(pkt_out_data), .pkt_out_slot(pkt_out_slot),
    .pkt_out_pad(pkt_out_pad), .pkt_out_last(pkt_out_last), .pkt_grant_in(pkt_grant_in),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_slot(cmd_slot), .cmd_last(cmd_last),
    .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_pad(rsp_pad), .rsp_last(rsp_last),
    .rsp_ready(rsp_ready),
    .err_slot_mismatch(err_slot_mismatch), .rx_msg_count(rx_msg_count),
    .tx_msg_count(tx_msg_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] slot;
    logic          last;
  } cmd_exp_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] slot;
    logic [PW-1:0] pad;
    logic          last;
  } pkt_exp_t;

  cmd_exp_t cmd_q[$];
  pkt_exp_t pkt_q[$];
  cmd_exp_t cmd_e;
  pkt_exp_t pkt_e;
  int n_compared = 0;
  int n_mismatched = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Command stream monitor
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      check("cmd beat expected", DW'(cmd_q.size() != 0), DW'(1));
      if (cmd_q.size() != 0) begin
        cmd_e = cmd_q.pop_front();
        check("cmd_data", cmd_data, cmd_e.data);
        check("cmd_slot", DW'(cmd_slot), DW'(cmd_e.slot));
        check("cmd_last", DW'(cmd_last), DW'(cmd_e.last));
      end
    end
  end

  // Outgoing packet monitor
  always @(negedge clk) begin
    if (rst_n && pkt_out_valid && pkt_grant_in) begin
      check("pkt_out beat expected", DW'(pkt_q.size() != 0), DW'(1));
      if (pkt_q.size() != 0) begin
        pkt_e = pkt_q.pop_front();
        check("pkt_out_data", pkt_out_data, pkt_e.data);
        check("pkt_out_slot", DW'(pkt_out_slot), DW'(pkt_e.slot));
        check("pkt_out_pad", DW'(pkt_out_pad), DW'(pkt_e.pad));
        check("pkt_out_last", DW'(pkt_out_last), DW'(pkt_e.last));
      end
    end
  end

  task automatic send_pkt(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l,
                          input bit expect_cmd);
    int waited;
    waited = 0;
    if (expect_cmd) cmd_q.push_back('{d, s, l});
    pkt_in_data  = d;
    pkt_in_slot  = s;
    pkt_in_last  = l;
    pkt_in_valid = 1'b1;
    @(negedge clk);
    while (pkt_full_out && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("rx accept in time", DW'(pkt_full_out), DW'(0));
    @(posedge clk);
    #1;
    pkt_in_valid = 1'b0;
  endtask

  task automatic send_rsp(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic l,
                          input logic [SW-1:0] exp_slot, input bit expect_pkt);
    int waited;
    waited = 0;
    if (expect_pkt) pkt_q.push_back('{d, exp_slot, p, l});
    rsp_data  = d;
    rsp_pad   = p;
    rsp_last  = l;
    rsp_valid = 1'b1;
    @(negedge clk);
    while (!rsp_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("rsp accept in time", DW'(rsp_ready), DW'(1));
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_drained();
    check("cmd queue drained", DW'(cmd_q.size()), DW'(0));
    check("pkt queue drained", DW'(pkt_q.size()), DW'(0));
    cmd_q.delete();
    pkt_q.delete();
  endtask

  task automatic reset_dut();
    pkt_in_valid = 1'b0;
    rsp_valid    = 1'b0;
    cmd_ready    = 1'b0;
    pkt_grant_in = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    check("reset pkt_full_out", DW'(pkt_full_out), DW'(0));
    check("reset pkt_out_valid", DW'(pkt_out_valid), DW'(0));
    check("reset cmd_valid", DW'(cmd_valid), DW'(0));
    check("reset rsp_ready", DW'(rsp_ready), DW'(0));
    check("reset err", DW'(err_slot_mismatch), DW'(0));
    check("reset rx_msg_count", DW'(rx_msg_count), DW'(0));
    check("reset tx_msg_count", DW'(tx_msg_count), DW'(0));
    reset_dut();

    // Single-beat message
    cmd_ready = 1'b1;
    send_pkt(128'hA5, 16'd3, 1'b1, 1'b1);
    check("single cmd_valid", DW'(cmd_valid), DW'(1));
    check("single cmd_slot", DW'(cmd_slot), DW'(3));
    check("single cmd_last", DW'(cmd_last), DW'(1));
    check("single rx_msg_count", DW'(rx_msg_count), DW'(1));
    wait_cycles(3);
    check_drained();
    reset_dut();

    // Full round trip with grant held low, then released
    cmd_ready = 1'b1;
    send_pkt(128'h11, 16'd7, 1'b0, 1'b1);
    send_pkt(128'h22, 16'd7, 1'b0, 1'b1);
    send_pkt(128'h33, 16'd7, 1'b1, 1'b1);
    wait_cycles(3);
    check("trip rx_msg_count", DW'(rx_msg_count), DW'(1));
    check("trip rsp_ready", DW'(rsp_ready), DW'(1));
    send_rsp(128'hB1, 4'd1, 1'b0, 16'd7, 1'b1);
    send_rsp(128'hB2, 4'd2, 1'b1, 16'd7, 1'b1);
    check("trip rsp_ready after last", DW'(rsp_ready), DW'(0));
    repeat (3) begin
      @(negedge clk);
      check("stall pkt_out_valid", DW'(pkt_out_valid), DW'(1));
      check("stall pkt_out_data", pkt_out_data, 128'hB1);
      check("stall pkt_out_slot", DW'(pkt_out_slot), DW'(7));
      check("stall pkt_out_last", DW'(pkt_out_last), DW'(0));
    end
    @(posedge clk);
    #1;
    pkt_grant_in = 1'b1;
    wait_cycles(4);
    pkt_grant_in = 1'b0;
    check("trip drained pkt_out_valid", DW'(pkt_out_valid), DW'(0));
    check("trip tx_msg_count", DW'(tx_msg_count), DW'(1));
    check_drained();
    reset_dut();

    // Fill the receive FIFO, hold a 17th beat until one command pop
    cmd_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_pkt(DW'(32'h100 + i), 16'd9, 1'b0, 1'b1);
    check("fill pkt_full_out", DW'(pkt_full_out), DW'(1));
    cmd_q.push_back('{DW'(32'h110), 16'd9, 1'b1});
    pkt_in_data  = DW'(32'h110);
    pkt_in_slot  = 16'd9;
    pkt_in_last  = 1'b1;
    pkt_in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("held pkt_full_out", DW'(pkt_full_out), DW'(1));
      check("held head data", cmd_data, DW'(32'h100));
    end
    check("held rx_msg_count", DW'(rx_msg_count), DW'(0));
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_ready = 1'b0;
    @(negedge clk);
    check("after pop pkt_full_out", DW'(pkt_full_out), DW'(0));
    @(posedge clk);
    #1;
    pkt_in_valid = 1'b0;
    check("17th captured once", DW'(pkt_full_out), DW'(1));
    check("fill rx_msg_count", DW'(rx_msg_count), DW'(1));
    cmd_ready = 1'b1;
    wait_cycles(20);
    check("fill drained cmd_valid", DW'(cmd_valid), DW'(0));
    check("fill drained full", DW'(pkt_full_out), DW'(0));
    check_drained();
    reset_dut();

    // Slot mismatch inside a message
    cmd_ready = 1'b1;
    send_pkt(128'h41, 16'd2, 1'b0, 1'b1);
    check("pre-mismatch err", DW'(err_slot_mismatch), DW'(0));
    send_pkt(128'h42, 16'd5, 1'b0, 1'b0);
    check("mismatch err", DW'(err_slot_mismatch), DW'(1));
    send_pkt(128'h43, 16'd2, 1'b1, 1'b1);
    wait_cycles(3);
    check("mismatch rx_msg_count", DW'(rx_msg_count), DW'(1));
    check("mismatch err sticky", DW'(err_slot_mismatch), DW'(1));
    check_drained();
    reset_dut();

    // Slot queue full: fifth command waits for a response
    cmd_ready    = 1'b1;
    pkt_grant_in = 1'b1;
    for (int i = 0; i < 5; i++) send_pkt(DW'(32'h50 + i), SW'(i), 1'b1, 1'b1);
    wait_cycles(3);
    check("sq full cmd_valid", DW'(cmd_valid), DW'(0));
    check("sq full rsp_ready", DW'(rsp_ready), DW'(1));
    check("sq full rx_msg_count", DW'(rx_msg_count), DW'(5));
    send_rsp(128'hC0, 4'd0, 1'b1, 16'd0, 1'b1);
    check("sq freed cmd_valid", DW'(cmd_valid), DW'(1));
    for (int i = 1; i < 5; i++) send_rsp(DW'(32'hC0 + i), PW'(i), 1'b1, SW'(i), 1'b1);
    wait_cycles(4);
    check("sq tx_msg_count", DW'(tx_msg_count), DW'(5));
    check("sq rsp_ready empty", DW'(rsp_ready), DW'(0));
    check_drained();
    reset_dut();

    // Reset mid-message and mid-response
    cmd_ready = 1'b1;
    send_pkt(128'h40, 16'd4, 1'b1, 1'b1);
    wait_cycles(2);
    send_rsp(128'hE0, 4'd0, 1'b0, 16'd4, 1'b0);
    send_pkt(128'h61, 16'd6, 1'b0, 1'b1);
    wait_cycles(2);
    check("pre-reset pkt_out_valid", DW'(pkt_out_valid), DW'(1));
    check("pre-reset rsp_ready", DW'(rsp_ready), DW'(1));
    check("pre-reset rx_msg_count", DW'(rx_msg_count), DW'(1));
    check_drained();
    #2;
    rst_n = 1'b0;
    #1;
    check("async pkt_out_valid", DW'(pkt_out_valid), DW'(0));
    check("async cmd_valid", DW'(cmd_valid), DW'(0));
    check("async rsp_ready", DW'(rsp_ready), DW'(0));
    check("async pkt_full_out", DW'(pkt_full_out), DW'(0));
    check("async err", DW'(err_slot_mismatch), DW'(0));
    check("async rx_msg_count", DW'(rx_msg_count), DW'(0));
    check("async tx_msg_count", DW'(tx_msg_count), DW'(0));
    reset_dut();
    cmd_ready    = 1'b1;
    pkt_grant_in = 1'b1;
    send_pkt(128'h77, 16'd1, 1'b1, 1'b1);
    check("post-reset rx_msg_count", DW'(rx_msg_count), DW'(1));
    wait_cycles(2);
    send_rsp(128'hD0, 4'd3, 1'b1, 16'd1, 1'b1);
    wait_cycles(3);
    check("post-reset tx_msg_count", DW'(tx_msg_count), DW'(1));
    check("post-reset err", DW'(err_slot_mismatch), DW'(0));
    check_drained();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
